spi_arbiter: RTL and testbench
==============================

// Module: spi_arbiter
// PURPOSE
//   Shares one spi_master among N_REQ requesters with round-robin arbitration.
//   Per transfer it latches the granted requester's byte, pulses the master's start,
//   tracks SS low->high to detect completion, and returns the received byte.
//   A timeout guards against a stalled master.
//   Sits between local clients and spi_master; spi_master runs on the same clk.
// PARAMETERS
//   N_REQ      4   number of requesters (2..8)
//   DATA_W     8   transfer width; equals spi_master data width
//   START_CYC  2   clk cycles m_start is held high (>=1)
//   TIMEOUT    64  max clk cycles spent in WAIT_LO or in WAIT_HI before abort
// PORTS
//   clk         in   1             system clock, rising edge
//   rst_n       in   1             asynchronous reset, active low
//   req         in   N_REQ         request per requester, level; held until rvalid/err
//   wdata       in   N_REQ*DATA_W  byte to send; slice i belongs to requester i
//   gnt         out  N_REQ         one-hot; marks the requester owning the current transfer
//   rdata       out  DATA_W        received byte; valid while any rvalid bit is high
//   rvalid      out  N_REQ         1-cycle completion pulse to the owning requester
//   err         out  N_REQ         1-cycle timeout pulse to the owning requester
//   m_start     out  1             to spi_master start
//   m_data_out  out  DATA_W        to spi_master data_out; stable for the whole transfer
//   m_data_in   in   DATA_W        from spi_master data_in
//   m_ss        in   1             spi_master SS, active low
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, rr_ptr=0, all outputs 0 (m_data_out=0, rdata=0).
//   FSM states: IDLE, START, WAIT_LO, WAIT_HI, DONE.
//   IDLE: if |req, select the first set bit scanning from rr_ptr upward with wrap.
//     Register gnt, latch wdata slice into m_data_out, then go to START.
//   START: m_start=1 for START_CYC cycles, then go to WAIT_LO.
//   WAIT_LO: wait for m_ss==0, then go to WAIT_HI.
//     Timeout: after TIMEOUT cycles, pulse err[g] and return to IDLE.
//   WAIT_HI: wait for m_ss==1, then capture m_data_in into rdata and go to DONE.
//     Timeout: after TIMEOUT cycles, pulse err[g] and return to IDLE.
//   DONE: rvalid[g]=1 for one cycle, clear gnt, set rr_ptr=(g+1)%N_REQ, go to IDLE.
//   Latency: req seen in IDLE -> m_start high 1 cycle later. Transfer time is set by the master.
//   Back-to-back: a requester may reassert req; it is regranted no earlier than the IDLE cycle after DONE.
//   Fairness: any pending requester is served within N_REQ-1 other transfers.
//   Requester deasserting req mid-transfer: no abort; the transfer completes and rvalid still pulses.
//   Simultaneous requests in IDLE: rr_ptr order decides; the others wait.
//   Timeout counter: cleared on each state entry, saturates at TIMEOUT.
//     err and rvalid are never high in the same cycle.
//     After a timeout abort, rr_ptr still advances past the aborted requester.
//   Reset mid-transfer: immediate return to IDLE and m_start drops.
//     The spi_master is reset by the same rst_n.
//   gnt, m_start and m_data_out are registered; no combinational path from req to m_start.
// STRUCTURE
//   spi_pkg: state encoding localparams (IDLE..DONE), DATA_W default, clog2 helper.
//   Sub-module rr_pick: combinational round-robin picker.
//     Inputs req, rr_ptr. Outputs one-hot pick and its index.
//   Everything else (FSM, counters, latches) lives in spi_arbiter.
// TESTING
//   1 single: req[0]=1, wdata[0]=134, slave data_out=79
//     -> m_start high 2 cycles; rvalid[0] pulses once with rdata=79; slave receives 134.
//   2 contention: req=4'b1011 at once, all held
//     -> service order 0,1,3, then 0 again if still held; gnt is always one-hot.
//   3 fairness: req[0] held permanently, req[2] raised mid-transfer
//     -> req[2] is served next, before 0 is regranted.
//   4 stall: m_ss tied 1
//     -> err[g] pulses 1+START_CYC+TIMEOUT cycles after the grant; no rvalid; FSM back in IDLE.
//   5 reset: rst_n=0 during WAIT_HI
//     -> all outputs 0 asynchronously; after release, a new req[1] completes normally.
//   6 drop: req[1] deasserted after grant -> transfer finishes; rvalid[1] still pulses.

Source files
------------

// File: rtl/spi_arbiter_pkg.sv
// Shared types and helpers for the SPI arbiter.
package spi_arbiter_pkg;

    localparam int unsigned DefDataW = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitLo,
        StWaitHi,
        StDone
    } state_e;

    // Ceiling log2, never below 1 so a one-bit index still has a width.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, with wrap.
module spi_arbiter_rr_pick
    import spi_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IdxW = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IdxW-1:0]  rr_ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IdxW-1:0]  idx
);

    localparam int unsigned SumW = IdxW + 1;

    logic [N_REQ-1:0] rotated;
    logic [SumW-1:0]  sum;
    logic             found;

    // Rotate req so bit 0 is rr_ptr, take the lowest set bit, then map back.
    always_comb begin
        rotated = N_REQ'({req, req} >> rr_ptr);
        found   = 1'b0;
        sum     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && rotated[i]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr} + SumW'(i);
            end
        end
        if (sum >= SumW'(N_REQ)) begin
            sum = sum - SumW'(N_REQ);
        end
        idx = sum[IdxW-1:0];
        for (int unsigned j = 0; j < N_REQ; j++) begin
            pick[j] = found && (idx == IdxW'(j));
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin sharing of one spi_master among N_REQ local requesters.
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned START_CYC = 2,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [DATA_W-1:0]         rdata,
    output logic [N_REQ-1:0]          rvalid,
    output logic [N_REQ-1:0]          err,
    output logic                      m_start,
    output logic [DATA_W-1:0]         m_data_out,
    input  logic [DATA_W-1:0]         m_data_in,
    input  logic                      m_ss
);

    localparam int unsigned IdxW   = clog2(N_REQ);
    localparam int unsigned CntMax = (TIMEOUT > START_CYC) ? TIMEOUT : START_CYC;
    localparam int unsigned CntW   = clog2(CntMax + 1);

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                m_start_q, m_start_d;
    logic [DATA_W-1:0]   m_data_out_q, m_data_out_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [N_REQ-1:0]    rvalid_q, rvalid_d;
    logic [N_REQ-1:0]    err_q, err_d;

    logic [N_REQ-1:0]    pick;
    logic [IdxW-1:0]     pick_idx;
    logic [DATA_W-1:0]   pick_data;
    logic [IdxW-1:0]     next_ptr;

    spi_arbiter_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .pick   (pick),
        .idx    (pick_idx)
    );

    // Select the write byte of the requester about to be granted.
    always_comb begin
        pick_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                pick_data = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign next_ptr = (idx_q == IdxW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;

    // Transfer sequencing, timeout abort and next-state for all registers.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        idx_d        = idx_q;
        rr_ptr_d     = rr_ptr_q;
        m_start_d    = m_start_q;
        m_data_out_d = m_data_out_q;
        rdata_d      = rdata_q;
        rvalid_d     = '0;
        err_d        = '0;

        unique case (state_q)
            StIdle: begin
                // Skip the cycle carrying an err pulse so the aborted requester can drop req.
                if (|req && !(|err_q)) begin
                    state_d      = StStart;
                    gnt_d        = pick;
                    idx_d        = pick_idx;
                    m_data_out_d = pick_data;
                    m_start_d    = 1'b1;
                end
            end
            StStart: begin
                if (cnt_q == CntW'(START_CYC - 1)) begin
                    state_d   = StWaitLo;
                    m_start_d = 1'b0;
                end
            end
            StWaitLo: begin
                if (!m_ss) begin
                    state_d = StWaitHi;
                end else if (cnt_q == CntW'(TIMEOUT)) begin
                    state_d  = StIdle;
                    err_d    = gnt_q;
                    gnt_d    = '0;
                    rr_ptr_d = next_ptr;
                end
            end
            StWaitHi: begin
                if (m_ss) begin
                    state_d  = StDone;
                    rdata_d  = m_data_in;
                    rvalid_d = gnt_q;
                end else if (cnt_q == CntW'(TIMEOUT)) begin
                    state_d  = StIdle;
                    err_d    = gnt_q;
                    gnt_d    = '0;
                    rr_ptr_d = next_ptr;
                end
            end
            StDone: begin
                state_d  = StIdle;
                gnt_d    = '0;
                rr_ptr_d = next_ptr;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Shared START/timeout counter: restarts on every state change, saturates.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(CntMax)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            gnt_q        <= '0;
            idx_q        <= '0;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            m_start_q    <= 1'b0;
            m_data_out_q <= '0;
            rdata_q      <= '0;
            rvalid_q     <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            idx_q        <= idx_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            m_start_q    <= m_start_d;
            m_data_out_q <= m_data_out_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            err_q        <= err_d;
        end
    end

    assign gnt        = gnt_q;
    assign rdata      = rdata_q;
    assign rvalid     = rvalid_q;
    assign err        = err_q;
    assign m_start    = m_start_q;
    assign m_data_out = m_data_out_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a simple spi_master behavioural model.
module tb_spi_arbiter;

    localparam int unsigned N_REQ     = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned START_CYC = 2;
    localparam int unsigned TIMEOUT   = 64;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [DATA_W-1:0]       rdata;
    logic [N_REQ-1:0]        rvalid;
    logic [N_REQ-1:0]        err;
    logic                    m_start;
    logic [DATA_W-1:0]       m_data_out;
    logic [DATA_W-1:0]       m_data_in;
    logic                    m_ss;

    // Master model controls and observations.
    logic [DATA_W-1:0] slave_dout;
    logic [DATA_W-1:0] slave_rx;
    logic              stall;
    logic              mbusy;
    int                mcnt;

    // Monitor tallies.
    int rv_cnt = 0, err_cnt = 0, start_cnt = 0, onehot_bad = 0, overlap_bad = 0;
    int order[$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_arbiter #(
        .N_REQ     (N_REQ),
        .DATA_W    (DATA_W),
        .START_CYC (START_CYC),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .wdata      (wdata),
        .gnt        (gnt),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .err        (err),
        .m_start    (m_start),
        .m_data_out (m_data_out),
        .m_data_in  (m_data_in),
        .m_ss       (m_ss)
    );

    // spi_master stand-in: SS low a cycle after start, back high after a few cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ss      <= 1'b1;
            mbusy     <= 1'b0;
            mcnt      <= 0;
            m_data_in <= '0;
        end else if (!mbusy) begin
            if (m_start && !stall) begin
                mbusy <= 1'b1;
                mcnt  <= 0;
            end
        end else begin
            mcnt <= mcnt + 1;
            if (mcnt == 1) m_ss <= 1'b0;
            if (mcnt == 6) begin
                m_ss      <= 1'b1;
                m_data_in <= slave_dout;
                slave_rx  <= m_data_out;
                mbusy     <= 1'b0;
            end
        end
    end

    // Observe outputs away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt != '0 && !$onehot(gnt)) onehot_bad++;
            if (|rvalid && |err) overlap_bad++;
            if (m_start) start_cnt++;
            if (|err) err_cnt++;
            if (|rvalid) begin
                rv_cnt++;
                for (int i = 0; i < int'(N_REQ); i++) if (rvalid[i]) order.push_back(i);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (gnt !== '0 || rvalid !== '0 || err !== '0) begin
            failures++;
            $display("FAIL reset_handshake gnt=%b rvalid=%b err=%b expected all 0", gnt, rvalid, err);
        end
        checks++;
        if (m_start !== 1'b0 || m_data_out !== '0 || rdata !== '0) begin
            failures++;
            $display("FAIL reset_data m_start=%b m_data_out=%h rdata=%h expected 0", m_start,
                     m_data_out, rdata);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (gnt !== '0 || m_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle gnt=%b m_start=%b expected 0000/0", gnt, m_start);
        end
    endtask

    task automatic test_contention();
        int base;
        int exp_order[4] = '{0, 1, 3, 0};
        base = order.size();
        slave_dout = 8'h11;
        req = 4'b1011;
        for (int k = 0; k < 400 && (order.size() - base) < 4; k++) begin
            @(negedge clk);
            if ((order.size() - base) >= 4) req = '0;
        end
        req = '0;
        repeat (15) @(negedge clk);
        checks++;
        if (order.size() - base < 4) begin
            failures++;
            $display("FAIL contention_count got=%0d expected 4", order.size() - base);
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (order[base+j] != exp_order[j]) begin
                    failures++;
                    $display("FAIL contention_order slot=%0d got=%0d expected %0d", j,
                             order[base+j], exp_order[j]);
                end
            end
        end
    endtask

    task automatic test_single();
        int s_rv, s_st, s_err;
        logic got;
        slave_dout    = 8'd79;
        wdata[7:0]    = 8'd134;
        s_rv  = rv_cnt;
        s_st  = start_cnt;
        s_err = err_cnt;
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if (m_start !== 1'b1 || gnt !== 4'b0001) begin
            failures++;
            $display("FAIL single_latency m_start=%b gnt=%b expected 1/0001", m_start, gnt);
        end
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (rvalid[0]) begin
                got = 1'b1;
                req = '0;
                checks++;
                if (rdata !== 8'd79) begin
                    failures++;
                    $display("FAIL single_rdata got=%0d expected 79", rdata);
                end
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL single_done got=no_rvalid expected rvalid[0]");
        end
        req = '0;
        repeat (10) @(negedge clk);
        checks++;
        if (rv_cnt - s_rv != 1) begin
            failures++;
            $display("FAIL single_rvalid_count got=%0d expected 1", rv_cnt - s_rv);
        end
        checks++;
        if (start_cnt - s_st != int'(START_CYC)) begin
            failures++;
            $display("FAIL single_start_len got=%0d expected %0d", start_cnt - s_st, START_CYC);
        end
        checks++;
        if (slave_rx !== 8'd134 || err_cnt != s_err) begin
            failures++;
            $display("FAIL single_slave_rx got=%0d errs=%0d expected 134/0", slave_rx,
                     err_cnt - s_err);
        end
    endtask

    task automatic test_fairness();
        int base;
        int exp_order[3] = '{0, 2, 0};
        logic seen;
        base = order.size();
        req = 4'b0001;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = gnt[0];
        end
        repeat (3) @(negedge clk);
        req[2] = 1'b1;
        for (int k = 0; k < 400 && (order.size() - base) < 3; k++) begin
            @(negedge clk);
            if (rvalid[2]) req[2] = 1'b0;
            if ((order.size() - base) >= 3) req = '0;
        end
        req = '0;
        repeat (15) @(negedge clk);
        checks++;
        if (order.size() - base < 3) begin
            failures++;
            $display("FAIL fairness_count got=%0d expected 3", order.size() - base);
        end else begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (order[base+j] != exp_order[j]) begin
                    failures++;
                    $display("FAIL fairness_order slot=%0d got=%0d expected %0d", j,
                             order[base+j], exp_order[j]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int s_rv, k_err;
        s_rv  = rv_cnt;
        k_err = -1;
        stall = 1'b1;
        req   = 4'b0100;
        for (int k = 1; k <= 200 && k_err < 0; k++) begin
            @(negedge clk);
            if (err != '0) begin
                k_err = k;
                req   = '0;
                checks++;
                if (err !== 4'b0100 || gnt !== '0) begin
                    failures++;
                    $display("FAIL stall_err err=%b gnt=%b expected 0100/0000", err, gnt);
                end
            end
        end
        req = '0;
        checks++;
        if (k_err != int'(2 + START_CYC + TIMEOUT)) begin
            failures++;
            $display("FAIL stall_timing got=%0d expected %0d", k_err, 2 + START_CYC + TIMEOUT);
        end
        @(negedge clk);
        checks++;
        if (err !== '0) begin
            failures++;
            $display("FAIL stall_pulse err=%b expected 0000", err);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (gnt !== '0 || m_start !== 1'b0 || rv_cnt != s_rv) begin
            failures++;
            $display("FAIL stall_idle gnt=%b m_start=%b rvalids=%0d expected 0000/0/0", gnt,
                     m_start, rv_cnt - s_rv);
        end
        stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic lo, got;
        slave_dout   = 8'h5A;
        wdata[15:8]  = 8'hA5;
        req          = 4'b0010;
        lo = 1'b0;
        for (int k = 0; k < 50 && !lo; k++) begin
            @(negedge clk);
            lo = !m_ss;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, m_start, rvalid, err, m_data_out, rdata} !== '0) begin
            failures++;
            $display("FAIL reset_mid_async gnt=%b m_start=%b m_data_out=%h rdata=%h expected 0",
                     gnt, m_start, m_data_out, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (rvalid[1]) begin
                got = 1'b1;
                req = '0;
                checks++;
                if (rdata !== 8'h5A) begin
                    failures++;
                    $display("FAIL reset_mid_rdata got=%h expected 5a", rdata);
                end
            end
        end
        req = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (!got || slave_rx !== 8'hA5) begin
            failures++;
            $display("FAIL reset_mid_done done=%b slave_rx=%h expected 1/a5", got, slave_rx);
        end
    endtask

    task automatic test_drop();
        logic seen, got;
        slave_dout  = 8'h3C;
        wdata[15:8] = 8'hC3;
        req = 4'b0010;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = gnt[1];
        end
        req = '0;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (rvalid[1]) begin
                got = 1'b1;
                checks++;
                if (rdata !== 8'h3C) begin
                    failures++;
                    $display("FAIL drop_rdata got=%h expected 3c", rdata);
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (!got || slave_rx !== 8'hC3) begin
            failures++;
            $display("FAIL drop_done done=%b slave_rx=%h expected 1/c3", got, slave_rx);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        wdata      = '0;
        slave_dout = '0;
        slave_rx   = '0;
        stall      = 1'b0;
        test_reset();
        test_contention();
        test_single();
        test_fairness();
        test_stall();
        test_reset_mid();
        test_drop();
        checks++;
        if (onehot_bad != 0 || overlap_bad != 0) begin
            failures++;
            $display("FAIL invariants onehot_bad=%0d overlap_bad=%0d expected 0/0", onehot_bad,
                     overlap_bad);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
